reg_bank: RTL
=============

# reg_bank

Parametrised general-purpose register bank for the simple-viii datapath, the successor to the single temporary register. It holds `DEPTH` registers of `WIDTH` bits behind one shared data bus and adds in-place increment, decrement and clear, plus registered zero and carry flags. It sits between the control unit, which drives `op` and `sel`, and the shared internal bus, which it reads from and drives.

## Interface
Parameters:
- `WIDTH`, 8: register and bus width in bits, minimum 2.
- `DEPTH`, 4: number of registers, minimum 1.
- `RESET_VALUE`, 0: value loaded into every register on reset.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in`  in  WIDTH: bus data, written by LOAD.
- `out`  out  WIDTH: bus drive, active during ENABLE only.
- `op`  in  `reg_bank_op_e`: operation for this cycle.
- `sel`  in  SEL_W = max(1, $clog2(DEPTH)): register index.
- `zero`  out  1: registered; set when the last written value was 0.
- `carry`  out  1: registered; records wrap on INC or borrow on DEC.

## Operation
- Ops, one per cycle: `RB_NOP`, `RB_LOAD`, `RB_ENABLE`, `RB_INC`, `RB_DEC`, `RB_CLEAR`.
- `RB_LOAD`: `bank[sel] <= in`.
- `RB_INC`: `bank[sel] <= bank[sel] + 1`, modulo 2^WIDTH.
- `RB_DEC`: `bank[sel] <= bank[sel] - 1`, modulo 2^WIDTH.
- `RB_CLEAR`: `bank[sel] <= 0`.
- `RB_ENABLE`: `out = bank[sel]` combinationally. No state change.
- `RB_NOP`: no state change.
- Unselected registers always hold their value.
- `zero`: after LOAD, INC, DEC or CLEAR it equals (new value == 0). It holds on NOP and ENABLE.
- `carry`:
  - INC from all-ones to 0: set to 1.
  - DEC from 0 to all-ones: set to 1.
  - Any other INC or DEC: cleared to 0.
  - LOAD and CLEAR: cleared to 0.
  - NOP and ENABLE: held.
- `sel` >= DEPTH (possible only when DEPTH is not a power of two):
  - Every op behaves as NOP.
  - Flags hold.
  - `out` takes its idle value.
- Reset: all registers take RESET_VALUE. `zero` = (RESET_VALUE == 0), `carry` = 0. `out` is at its idle value whenever `op` is not ENABLE.

## Timing
- Write ops take effect at the rising edge that ends the cycle. The new value is visible on `out` via ENABLE in the following cycle, giving read-after-write latency 1.
- ENABLE has zero latency: `out` follows `sel` combinationally within the cycle.
- Flags update on the same edge as the register write.
- `reset` asserted mid-cycle clears state immediately, regardless of `clock` or `op`. Reset beats any concurrent op. The first op after deassertion acts at the next rising edge.
- Inputs must be stable around the rising edge. No handshake; the control unit issues exactly one op per cycle.

## Configuration
- `REG_BANK_TRISTATE_EN` defined: `out` is `'z` when not in ENABLE or when `sel` is out of range, for a shared tristate bus.
- `REG_BANK_TRISTATE_EN` undefined: `out` drives all-zeros in those cases, so external OR-muxing works on targets without internal tristates.
- Flags and register behaviour are identical in both builds.

## Structure
- `reg_bank_op_e` lives in the shared `control` package, next to `reg_op_e`, as a 3-bit enum: NOP=0, LOAD=1, ENABLE=2, INC=3, DEC=4, CLEAR=5. Undefined encodings behave as NOP.
- One sub-module, `reg_cell`, holds one WIDTH-bit register:
  - Inputs: write-enable, op and data.
  - Outputs: its value and its next-value carry/borrow.
  - `reg_bank` instantiates DEPTH copies, decodes `sel`, and muxes the outputs and flags.

## Test plan
- Reset with RESET_VALUE=0 and op NOP, then ENABLE on each sel -> `out`=0x00, `zero`=1, `carry`=0.
- LOAD sel=2 in=0xA5, next cycle ENABLE sel=2 -> `out`=0xA5 and `zero`=0. ENABLE sel=1 -> `out`=0x00.
- Counter wrap:
  - LOAD sel=0 in=0xFF, then INC sel=0 -> `out`=0x00, `zero`=1, `carry`=1.
  - DEC sel=0 -> `out`=0xFF, `zero`=0, `carry`=1.
  - INC sel=0 -> `out`=0x00, `zero`=1, `carry`=1.
- Flag hold: after the wrap, NOP and ENABLE for 3 cycles -> flags unchanged. A LOAD of 0x10 then gives `carry`=0, `zero`=0.
- Async reset: assert `reset` between edges during an INC sequence -> registers read RESET_VALUE immediately and the INC is lost. Count resumes from RESET_VALUE after deassert.
- DEPTH=3 with `sel`=3 and LOAD in=0x55 -> no register changes. `out` is `'z` (macro defined) or 0x00 (undefined) under ENABLE sel=3.

Source files
------------

// File: rtl/control_pkg.sv
// Shared control-unit encodings for the simple-viii datapath, including the
// register bank op set and a write-op classifier used by the bank.
package control;

  // Original single temporary register op set.
  typedef enum logic [1:0] {
    REG_NOP    = 2'd0,
    REG_LOAD   = 2'd1,
    REG_ENABLE = 2'd2
  } reg_op_e;

  typedef enum logic [2:0] {
    RB_NOP    = 3'd0,
    RB_LOAD   = 3'd1,
    RB_ENABLE = 3'd2,
    RB_INC    = 3'd3,
    RB_DEC    = 3'd4,
    RB_CLEAR  = 3'd5
  } reg_bank_op_e;

  // True for ops that write a register and update the flags; undefined
  // encodings fall through to false so they act as NOP.
  function automatic logic rb_is_write(input reg_bank_op_e op);
    logic result;
    case (op)
      RB_LOAD, RB_INC, RB_DEC, RB_CLEAR: result = 1'b1;
      default:                           result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// One WIDTH-bit register of the bank: computes its next value and
// wrap/borrow for the current op and commits it when write-enabled.
module reg_cell
  import control::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  reg_bank_op_e       op,
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH-1:0]   value,
  output logic [WIDTH-1:0]   next_value,
  output logic               wrap
);

  // Next value and carry/borrow for the requested op.
  always_comb begin
    next_value = value;
    wrap       = 1'b0;
    case (op)
      RB_LOAD:  next_value = data;
      RB_INC:   {wrap, next_value} = {1'b0, value} + {{WIDTH{1'b0}}, 1'b1};
      RB_DEC: begin
        next_value = value - {{(WIDTH-1){1'b0}}, 1'b1};
        wrap       = (value == {WIDTH{1'b0}});
      end
      RB_CLEAR: next_value = {WIDTH{1'b0}};
      default: begin
        next_value = value;
        wrap       = 1'b0;
      end
    endcase
  end

  // Register storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= RESET_VALUE;
    end else if (we) begin
      value <= next_value;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// General-purpose register bank: DEPTH cells behind one shared bus with
// registered zero/carry flags. Define REG_BANK_TRISTATE_EN to float `out`
// when idle instead of driving zeros.
module reg_bank
  import control::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  localparam int              SEL_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in,
  output logic [WIDTH-1:0]   out,
  input  reg_bank_op_e       op,
  input  logic [SEL_W-1:0]   sel,
  output logic               zero,
  output logic               carry
);

  localparam logic RESET_ZERO = (RESET_VALUE == {WIDTH{1'b0}});

  logic [WIDTH-1:0] cell_value [DEPTH];
  logic [WIDTH-1:0] cell_next  [DEPTH];
  logic [DEPTH-1:0] cell_wrap;
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] we;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] nxt_val;
  logic             wrap_sel;
  logic             sel_ok;
  logic             wr;

  // One-hot select; an out-of-range sel leaves every bit low, which turns
  // every op into a NOP and idles the bus.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    assign hit[g] = (sel == SEL_W'(g));
    assign we[g]  = hit[g] & wr;

    reg_cell #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_cell (
      .clock      (clock),
      .reset      (reset),
      .we         (we[g]),
      .op         (op),
      .data       (in),
      .value      (cell_value[g]),
      .next_value (cell_next[g]),
      .wrap       (cell_wrap[g])
    );
  end

  assign sel_ok = |hit;
  assign wr     = sel_ok & rb_is_write(op);

  // AND-OR mux of the selected cell's current value, next value and wrap.
  always_comb begin
    rd_val   = {WIDTH{1'b0}};
    nxt_val  = {WIDTH{1'b0}};
    wrap_sel = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_val   = rd_val  | (cell_value[i] & {WIDTH{hit[i]}});
      nxt_val  = nxt_val | (cell_next[i]  & {WIDTH{hit[i]}});
      wrap_sel = wrap_sel | (cell_wrap[i] & hit[i]);
    end
  end

`ifdef REG_BANK_TRISTATE_EN
  assign out = ((op == RB_ENABLE) && sel_ok) ? rd_val : {WIDTH{1'bz}};
`else
  assign out = ((op == RB_ENABLE) && sel_ok) ? rd_val : {WIDTH{1'b0}};
`endif

  // Flags follow the value being written; reads and NOPs leave them alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      zero  <= RESET_ZERO;
      carry <= 1'b0;
    end else if (wr) begin
      zero  <= (nxt_val == {WIDTH{1'b0}});
      carry <= wrap_sel;
    end else begin
      zero  <= zero;
      carry <= carry;
    end
  end

endmodule
